// File: rtl/fp_norm_pipe.sv
// Two-stage normalizer for binary32 add/sub results: LZC + shift,
// carry handling, exponent adjust, zero/ovf/unf detection and packing.
`timescale 1ns/1ps

module lzc_24 (
  input  logic [23:0] a,
  output logic [4:0]  c,
  output logic        v
);
  always_comb begin
    c = '0;
    v = 1'b0;
    // last hit wins, so the highest set bit sets the count
    for (int i = 0; i < 24; i++) begin
      if (a[i]) begin
        c = 5'(23 - i);
        v = 1'b1;
      end
    end
  end
endmodule

module fp_norm_pipe #(
  parameter bit FLUSH_DENORM = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_man,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_inexact
);
  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q, s1_sign_d;
  logic [7:0]  s1_exp_q, s1_exp_d;
  logic [24:0] s1_man_q, s1_man_d;
  logic [4:0]  s1_lz_q, s1_lz_d;
  logic        s1_nz_q, s1_nz_d;
  logic        s1_carry_q, s1_carry_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic        out_zero_q, out_zero_d;
  logic        out_ovf_q, out_ovf_d;
  logic        out_unf_q, out_unf_d;
  logic        out_inexact_q, out_inexact_d;

  logic [4:0]  lz_c;
  logic        lz_v;
  logic        s2_ready, in_fire, s1_fire;

  logic [8:0]  exp_inc;
  logic [7:0]  exp_dec;
  logic [23:0] man_n;
  logic [4:0]  dn_sh;
  logic        is_big;
  logic [31:0] n_res;
  logic        n_zero, n_ovf, n_unf, n_inx;

  lzc_24 u_lzc (
    .a (in_man[23:0]),
    .c (lz_c),
    .v (lz_v)
  );

  assign s2_ready = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign in_fire  = in_valid && in_ready;
  assign s1_fire  = s1_valid_q && s2_ready;

  always_comb begin
    exp_inc = {1'b0, s1_exp_q} + 9'd1;
    exp_dec = s1_exp_q - {3'b0, s1_lz_q};
    is_big  = s1_exp_q > {3'b0, s1_lz_q};
    man_n   = '0;
    dn_sh   = '0;
    n_res   = '0;
    n_zero  = 1'b0;
    n_ovf   = 1'b0;
    n_unf   = 1'b0;
    n_inx   = 1'b0;
    unique case (1'b1)
      s1_carry_q: begin
        man_n = s1_man_q[24:1];
        if (exp_inc >= 9'd255) begin
          n_res = {s1_sign_q, 8'hFF, 23'b0};
          n_ovf = 1'b1;
          n_inx = 1'b1;
        end else begin
          n_res = {s1_sign_q, exp_inc[7:0], man_n[22:0]};
          n_inx = s1_man_q[0];
        end
      end
      (!s1_carry_q && !s1_nz_q): begin
        n_res  = {s1_sign_q, 31'b0};
        n_zero = 1'b1;
      end
      (!s1_carry_q && s1_nz_q && is_big): begin
        man_n = s1_man_q[23:0] << s1_lz_q;
        n_res = {s1_sign_q, exp_dec, man_n[22:0]};
      end
      default: begin
        n_unf = 1'b1;
        if (FLUSH_DENORM) begin
          n_res  = {s1_sign_q, 31'b0};
          n_zero = 1'b1;
          n_inx  = 1'b1;
        end else begin
          // exp <= lz <= 23 here, so the low 5 bits hold it
          dn_sh = (s1_exp_q == 8'd0) ? 5'd0 : s1_exp_q[4:0] - 5'd1;
          man_n = s1_man_q[23:0] << dn_sh;
          n_res = {s1_sign_q, 8'h00, man_n[22:0]};
        end
      end
    endcase
  end

  always_comb begin
    s1_valid_d = in_fire || (s1_valid_q && !s2_ready);
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_man_d   = s1_man_q;
    s1_lz_d    = s1_lz_q;
    s1_nz_d    = s1_nz_q;
    s1_carry_d = s1_carry_q;
    if (in_fire) begin
      s1_sign_d  = in_sign;
      s1_exp_d   = in_exp;
      s1_man_d   = in_man;
      s1_lz_d    = lz_c;
      s1_nz_d    = lz_v;
      s1_carry_d = in_man[24];
    end
    out_valid_d   = s1_fire || (out_valid_q && !out_ready);
    out_result_d  = out_result_q;
    out_zero_d    = out_zero_q;
    out_ovf_d     = out_ovf_q;
    out_unf_d     = out_unf_q;
    out_inexact_d = out_inexact_q;
    if (s1_fire) begin
      out_result_d  = n_res;
      out_zero_d    = n_zero;
      out_ovf_d     = n_ovf;
      out_unf_d     = n_unf;
      out_inexact_d = n_inx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_man_q      <= '0;
      s1_lz_q       <= '0;
      s1_nz_q       <= 1'b0;
      s1_carry_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_zero_q    <= 1'b0;
      out_ovf_q     <= 1'b0;
      out_unf_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_exp_q      <= s1_exp_d;
      s1_man_q      <= s1_man_d;
      s1_lz_q       <= s1_lz_d;
      s1_nz_q       <= s1_nz_d;
      s1_carry_q    <= s1_carry_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_zero_q    <= out_zero_d;
      out_ovf_q     <= out_ovf_d;
      out_unf_q     <= out_unf_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_zero    = out_zero_q;
  assign out_ovf     = out_ovf_q;
  assign out_unf     = out_unf_q;
  assign out_inexact = out_inexact_q;
endmodule

// File: tb/tb_fp_norm_pipe.sv
// Bench for fp_norm_pipe: directed table, backpressure/reset
// sequences and randomized traffic against a reference model.
`timescale 1ns/1ps

module tb_fp_norm_pipe;
  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        unf;
    logic        inx;
  } exp_t;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    exp_t        x;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_man;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_ovf, out_unf, out_inexact;

  int   checks = 0;
  int   errors = 0;
  exp_t cur_exp;
  exp_t sb[$];

  fp_norm_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_ovf(out_ovf), .out_unf(out_unf),
    .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  // Reference: value-level normalization of an unrounded sum.
  function automatic exp_t model(logic s, logic [7:0] e, logic [24:0] m);
    exp_t r;
    int ev, top, lz;
    logic [23:0] sh;
    r = '0;
    if (m[24]) begin
      ev = int'(e) + 1;
      if (ev >= 255) begin
        r.res = {s, 8'hFF, 23'b0};
        r.ovf = 1'b1;
        r.inx = 1'b1;
      end else begin
        sh = m[24:1];
        r.res = {s, 8'(ev), sh[22:0]};
        r.inx = m[0];
      end
    end else if (m == 0) begin
      r.res = {s, 31'b0};
      r.zero = 1'b1;
    end else begin
      top = 0;
      for (int i = 0; i < 24; i++) if (m[i]) top = i;
      lz = 23 - top;
      if (int'(e) > lz) begin
        sh = m[23:0] << lz;
        r.res = {s, 8'(int'(e) - lz), sh[22:0]};
      end else begin
        r.res = {s, 31'b0};
        r.zero = 1'b1;
        r.unf = 1'b1;
        r.inx = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(string n, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_beat: unexpected beat res=%h", out_result);
        end else begin
          exp_t w;
          w = sb.pop_front();
          if ({out_result, out_zero, out_ovf, out_unf, out_inexact} !== w) begin
            errors++;
            $display("FAIL out_beat: got res=%h z%b o%b u%b i%b want res=%h z%b o%b u%b i%b",
              out_result, out_zero, out_ovf, out_unf, out_inexact,
              w.res, w.zero, w.ovf, w.unf, w.inx);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic drive(logic s, logic [7:0] e, logic [24:0] m, exp_t x);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_man   = m;
    cur_exp  = x;
  endtask

  task automatic send(logic s, logic [7:0] e, logic [24:0] m, exp_t x);
    logic acc;
    int   n;
    drive(s, e, m, x);
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: in_ready stuck 0 want 1");
    end
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats missing want 0", sb.size());
    end
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{1'b0, 8'd127, 25'h0800000, {32'h3F800000, 4'b0000}};
    vt[1] = '{1'b0, 8'd127, 25'h0000001, {32'h34000000, 4'b0000}};
    vt[2] = '{1'b0, 8'd127, 25'h1000001, {32'h40000000, 4'b0001}};
    vt[3] = '{1'b0, 8'd254, 25'h1000000, {32'h7F800000, 4'b0101}};
    vt[4] = '{1'b1, 8'd50,  25'h0000000, {32'h80000000, 4'b1000}};
    vt[5] = '{1'b0, 8'd10,  25'h0000100, {32'h00000000, 4'b1011}};
    vt[6] = '{1'b0, 8'd15,  25'h0000100, {32'h00000000, 4'b1011}};
    vt[7] = '{1'b0, 8'd16,  25'h0000100, {32'h00800000, 4'b0000}};
    vt[8] = '{1'b1, 8'd253, 25'h1FFFFFF, {32'hFF7FFFFF, 4'b0001}};
    vt[9] = '{1'b1, 8'd0,   25'h0800000, {32'h80000000, 4'b1011}};

    rst = 1'b1;
    in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_man = '0;
    out_ready = 1'b0;
    cur_exp = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_result", 64'(out_result), 64'(0));
    chk("rst_flags", 64'({out_zero, out_ovf, out_unf, out_inexact}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // latency: accepted on one edge, visible after the next
    out_ready = 1'b1;
    drive(vt[0].s, vt[0].e, vt[0].m, vt[0].x);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_cycle1", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_cycle2", 64'(out_valid), 64'(1));
    chk("lat_result", 64'(out_result), 64'(32'h3F800000));
    drain();

    for (int i = 0; i < 10; i++) begin
      chk($sformatf("model_vec%0d", i), 64'(model(vt[i].s, vt[i].e, vt[i].m)),
          64'(vt[i].x));
      send(vt[i].s, vt[i].e, vt[i].m, vt[i].x);
    end
    drain();

    // backpressure: 4 beats, consumer stalled for 5 cycles
    out_ready = 1'b0;
    send(1'b0, 8'd100, 25'h0400000, model(1'b0, 8'd100, 25'h0400000));
    send(1'b1, 8'd200, 25'h1800003, model(1'b1, 8'd200, 25'h1800003));
    drive(1'b0, 8'd5, 25'h0000010, model(1'b0, 8'd5, 25'h0000010));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", c), 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(1'b0, 8'd5, 25'h0000010, model(1'b0, 8'd5, 25'h0000010));
    send(1'b0, 8'd30, 25'h0000F00, model(1'b0, 8'd30, 25'h0000F00));
    drain();

    // asynchronous reset mid-stream drops in-flight beats
    out_ready = 1'b0;
    send(1'b0, 8'd90, 25'h0800001, model(1'b0, 8'd90, 25'h0800001));
    send(1'b0, 8'd91, 25'h0800002, model(1'b0, 8'd91, 25'h0800002));
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_result", 64'(out_result), 64'(0));
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // random traffic with random backpressure
    for (int k = 0; k < 600; k++) begin
      logic        s;
      logic [7:0]  e;
      logic [24:0] m;
      s = 1'($urandom);
      e = 8'($urandom);
      case ($urandom_range(0, 4))
        0: m = 25'($urandom);
        1: m = {1'b0, 24'($urandom)};
        2: m = 25'($urandom) >> $urandom_range(1, 24);
        3: m = '0;
        default: begin
          m = 25'($urandom) >> $urandom_range(8, 24);
          e = 8'($urandom_range(0, 24));
        end
      endcase
      drive(s, e, m, model(s, e, m));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
